// File: rtl/synth_pkg.sv
// Shared command encodings, the FSM state type and the saturation helper
// used by the voice allocator and its mixer.
package synth_pkg;

  localparam logic       CMD_ON        = 1'b1;
  localparam logic       CMD_OFF       = 1'b0;
  localparam logic [6:0] MIDI_STOP_ALL = 7'h7F;

  // ST_HOLD is the single cycle after an accepted command (and after reset).
  typedef enum logic {
    ST_HOLD  = 1'b0,
    ST_READY = 1'b1
  } cmd_state_e;

  // Clamp a signed value to the range of a w-bit signed number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/voice_mixer.sv
// Two-stage mix pipeline: sum active voice samples on a tick, then shift
// by GAIN_SHIFT and saturate into the output register.
module voice_mixer
  import synth_pkg::*;
#(
  parameter int N_VOICES   = 16,
  parameter int SAMPLE_W   = 16,
  parameter int GAIN_SHIFT = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_tick,
  input  logic [N_VOICES-1:0]          i_active,
  input  logic [N_VOICES*SAMPLE_W-1:0] i_voice_sample,
  output logic [SAMPLE_W-1:0]          o_signal,
  output logic                         o_valid
);

  localparam int SUM_W = SAMPLE_W + $clog2(N_VOICES);

  logic signed [SUM_W-1:0] sum_d, sum_q;
  logic signed [SUM_W-1:0] shifted;
  logic                    tick_d, tick_q;
  logic [SAMPLE_W-1:0]     signal_d, signal_q;
  logic                    valid_d, valid_q;

  always_comb begin
    sum_d  = sum_q;
    tick_d = i_tick;
    if (i_tick) begin
      sum_d = '0;
      for (int k = 0; k < N_VOICES; k++) begin
        if (i_active[k]) begin
          sum_d = sum_d + SUM_W'($signed(i_voice_sample[k*SAMPLE_W +: SAMPLE_W]));
        end
      end
    end
  end

  always_comb begin
    shifted  = sum_q >>> GAIN_SHIFT;
    signal_d = signal_q;
    valid_d  = tick_q;
    if (tick_q) begin
      signal_d = SAMPLE_W'(saturate(64'(shifted), SAMPLE_W));
    end
  end

  // Reset drops any in-flight mix so no stale o_valid escapes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q    <= '0;
      tick_q   <= 1'b0;
      signal_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      tick_q   <= tick_d;
      signal_q <= signal_d;
      valid_q  <= valid_d;
    end
  end

  assign o_signal = signal_q;
  assign o_valid  = valid_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator with oldest-voice stealing and a saturating mixer.
// Define VOICE_STEAL_EN to steal on a full table; otherwise the note is dropped.
// Handshake: a command transfers on a cycle where i_valid && o_ready; o_ready
// then drops for exactly one cycle, so at most one command per two cycles.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int N_VOICES   = 16,
  parameter int MIDI_W     = 7,
  parameter int SAMPLE_W   = 16,
  parameter int GAIN_SHIFT = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [15:0]                    i_data,
  input  logic                           i_valid,
  output logic                           o_ready,
  output logic [N_VOICES-1:0]            o_voice_on,
  output logic [N_VOICES*MIDI_W-1:0]     o_voice_midi,
  input  logic [N_VOICES*SAMPLE_W-1:0]   i_voice_sample,
  input  logic                           i_sample_tick,
  output logic [SAMPLE_W-1:0]            o_signal,
  output logic                           o_valid,
  output logic                           o_overflow,
  output logic [$clog2(N_VOICES+1)-1:0]  o_active_count,
  output logic                           o_dbg_state
);

  localparam int AGE_W = $clog2(N_VOICES);
  localparam int CNT_W = $clog2(N_VOICES + 1);
  localparam logic [MIDI_W-1:0] STOP    = MIDI_W'(MIDI_STOP_ALL);
  localparam logic [AGE_W-1:0]  AGE_MAX = '1;

  cmd_state_e                        state_d, state_q;
  logic [N_VOICES-1:0]               active_d, active_q;
  logic [N_VOICES-1:0][MIDI_W-1:0]   midi_d, midi_q;
  logic [N_VOICES-1:0][AGE_W-1:0]    age_d, age_q;
  logic                              overflow_d, overflow_q;

  logic              accept;
  logic              cmd_on;
  logic [MIDI_W-1:0] cmd_midi;
  logic              hit, free_found, do_alloc, load;
  logic [AGE_W-1:0]  hit_idx, free_idx, target;
  logic [CNT_W-1:0]  count;
  logic              unused_velocity;
`ifdef VOICE_STEAL_EN
  logic [AGE_W-1:0]  oldest_idx, oldest_age;
`endif

  assign cmd_on          = (i_data[15] == CMD_ON);
  assign cmd_midi        = MIDI_W'(i_data[14:8]);
  assign unused_velocity = ^i_data[7:0];

  always_comb begin
    accept  = 1'b0;
    state_d = state_q;
    case (state_q)
      ST_READY: begin
        accept  = i_valid;
        state_d = i_valid ? ST_HOLD : ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  // Voice lookups: matching note, lowest free voice, oldest voice.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
`ifdef VOICE_STEAL_EN
    oldest_idx = '0;
    oldest_age = age_q[0];
`endif
    for (int k = 0; k < N_VOICES; k++) begin
      if (!hit && active_q[k] && (midi_q[k] == cmd_midi)) begin
        hit     = 1'b1;
        hit_idx = AGE_W'(k);
      end
      if (!free_found && !active_q[k]) begin
        free_found = 1'b1;
        free_idx   = AGE_W'(k);
      end
`ifdef VOICE_STEAL_EN
      if (age_q[k] > oldest_age) begin
        oldest_age = age_q[k];
        oldest_idx = AGE_W'(k);
      end
`endif
    end
  end

  always_comb begin
    active_d   = active_q;
    midi_d     = midi_q;
    age_d      = age_q;
    overflow_d = 1'b0;
    do_alloc   = 1'b0;
    load       = 1'b0;
    target     = '0;
    if (accept) begin
      if (cmd_on) begin
        if (cmd_midi != STOP) begin
          if (hit) begin
            do_alloc = 1'b1;
            target   = hit_idx;
          end else if (free_found) begin
            do_alloc = 1'b1;
            load     = 1'b1;
            target   = free_idx;
          end else begin
`ifdef VOICE_STEAL_EN
            do_alloc = 1'b1;
            load     = 1'b1;
            target   = oldest_idx;
`else
            overflow_d = 1'b1;
`endif
          end
        end
      end else if (cmd_midi == STOP) begin
        active_d = '0;
        midi_d   = {N_VOICES{STOP}};
        age_d    = '0;
      end else begin
        for (int k = 0; k < N_VOICES; k++) begin
          if (active_q[k] && (midi_q[k] == cmd_midi)) begin
            active_d[k] = 1'b0;
            midi_d[k]   = STOP;
            age_d[k]    = '0;
          end
        end
      end
    end
    // The chosen voice becomes youngest; every other active voice ages.
    if (do_alloc) begin
      for (int k = 0; k < N_VOICES; k++) begin
        if (AGE_W'(k) == target) begin
          active_d[k] = 1'b1;
          age_d[k]    = '0;
          if (load) midi_d[k] = cmd_midi;
        end else if (active_q[k] && (age_q[k] != AGE_MAX)) begin
          age_d[k] = age_q[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    count = '0;
    for (int k = 0; k < N_VOICES; k++) begin
      count = count + CNT_W'(active_q[k]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_HOLD;
      active_q   <= '0;
      midi_q     <= {N_VOICES{STOP}};
      age_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      midi_q     <= midi_d;
      age_q      <= age_d;
      overflow_q <= overflow_d;
    end
  end

  // The mixer sees active_q, so a tick alongside a command uses the old mask.
  voice_mixer #(
    .N_VOICES  (N_VOICES),
    .SAMPLE_W  (SAMPLE_W),
    .GAIN_SHIFT(GAIN_SHIFT)
  ) u_mixer (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_tick        (i_sample_tick),
    .i_active      (active_q),
    .i_voice_sample(i_voice_sample),
    .o_signal      (o_signal),
    .o_valid       (o_valid)
  );

  assign o_ready        = (state_q == ST_READY);
  assign o_dbg_state    = state_q;
  assign o_voice_on     = active_q;
  assign o_voice_midi   = midi_q;
  assign o_overflow     = overflow_q;
  assign o_active_count = count;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator with N_VOICES=4, GAIN_SHIFT=0.
// Expectations follow VOICE_STEAL_EN when the bench is built with it.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int MW = 7;
  localparam int SW = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [15:0]       i_data;
  logic              i_valid;
  logic              o_ready;
  logic [NV-1:0]     o_voice_on;
  logic [NV*MW-1:0]  o_voice_midi;
  logic [NV*SW-1:0]  i_voice_sample;
  logic              i_sample_tick;
  logic [SW-1:0]     o_signal;
  logic              o_valid;
  logic              o_overflow;
  logic [2:0]        o_active_count;
  logic              o_dbg_state;

  int vectors = 0;
  int fails   = 0;

  voice_allocator #(
    .N_VOICES(NV), .MIDI_W(MW), .SAMPLE_W(SW), .GAIN_SHIFT(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_voice_on(o_voice_on), .o_voice_midi(o_voice_midi),
    .i_voice_sample(i_voice_sample), .i_sample_tick(i_sample_tick),
    .o_signal(o_signal), .o_valid(o_valid), .o_overflow(o_overflow),
    .o_active_count(o_active_count), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [15:0] on_cmd(input logic [6:0] n);
    return {1'b1, n, 8'h40};
  endfunction

  function automatic logic [15:0] off_cmd(input logic [6:0] n);
    return {1'b0, n, 8'h00};
  endfunction

  // ---------------- drivers ----------------
  // Waits (bounded) for o_ready, presents one command, returns at accept-edge + 1.
  task automatic send_cmd(input logic [15:0] d);
    int waited = 0;
    while (!o_ready && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    vectors++;
    if (!o_ready) begin
      fails++;
      $display("FAIL cmd_ready_timeout: o_ready=%b after %0d cycles, want 1", o_ready, waited);
    end
    i_data  = d;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // Pulses i_sample_tick with the given samples and reports latency to o_valid.
  task automatic tick_and_capture(input logic [NV*SW-1:0] smp,
                                  output logic [SW-1:0] sig, output int lat);
    i_voice_sample = smp;
    i_sample_tick  = 1'b1;
    @(posedge clk); #1;
    i_sample_tick = 1'b0;
    lat = -1;
    sig = 'x;
    for (int c = 1; c <= 5; c++) begin
      if (o_valid) begin
        lat = c;
        sig = o_signal;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n        = 1'b0;
    i_data         = '0;
    i_valid        = 1'b0;
    i_voice_sample = '0;
    i_sample_tick  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (o_voice_on !== 4'b0) begin fails++; $display("FAIL rst_voice_on: got %b want 0", o_voice_on); end
    vectors++; if (o_voice_midi !== {4{7'h7F}}) begin fails++; $display("FAIL rst_midi: got %h want %h", o_voice_midi, {4{7'h7F}}); end
    vectors++; if (o_active_count !== 3'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", o_active_count); end
    vectors++; if (o_signal !== 16'h0 || o_valid !== 1'b0 || o_overflow !== 1'b0) begin
      fails++; $display("FAIL rst_outputs: sig=%h valid=%b ovf=%b want 0/0/0", o_signal, o_valid, o_overflow);
    end
    vectors++; if (o_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", o_ready); end
    reset_n = 1'b1;
    vectors++; if (o_ready !== 1'b0) begin fails++; $display("FAIL rst_ready_release: got %b want 0", o_ready); end
    @(posedge clk); #1;
    vectors++; if (o_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_rise: got %b want 1", o_ready); end
  endtask

  task automatic test_alloc();
    send_cmd(on_cmd(7'h3C));
    vectors++; if (o_ready !== 1'b0) begin fails++; $display("FAIL alloc_ready_drop: got %b want 0", o_ready); end
    send_cmd(on_cmd(7'h40));
    send_cmd(on_cmd(7'h43));
    vectors++; if (o_voice_on !== 4'b0111) begin fails++; $display("FAIL alloc_on: got %b want 0111", o_voice_on); end
    vectors++; if (o_voice_midi !== {7'h7F, 7'h43, 7'h40, 7'h3C}) begin
      fails++; $display("FAIL alloc_midi: got %h want %h", o_voice_midi, {7'h7F, 7'h43, 7'h40, 7'h3C});
    end
    vectors++; if (o_active_count !== 3'd3) begin fails++; $display("FAIL alloc_count: got %0d want 3", o_active_count); end
  endtask

  task automatic test_full();
    logic [NV*MW-1:0] exp_midi;
    send_cmd(on_cmd(7'h47));
    vectors++; if (o_voice_on !== 4'b1111 || o_active_count !== 3'd4) begin
      fails++; $display("FAIL full_fill: on=%b cnt=%0d want 1111/4", o_voice_on, o_active_count);
    end
    // Ages now v0=3 v1=2 v2=1 v3=0; 0x48 finds no free voice.
    send_cmd(on_cmd(7'h48));
`ifdef VOICE_STEAL_EN
    exp_midi = {7'h47, 7'h43, 7'h40, 7'h48};
    vectors++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL full_steal_ovf: got %b want 0", o_overflow); end
`else
    exp_midi = {7'h47, 7'h43, 7'h40, 7'h3C};
    vectors++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL full_drop_ovf: got %b want 1", o_overflow); end
`endif
    vectors++; if (o_voice_midi !== exp_midi) begin fails++; $display("FAIL full_midi: got %h want %h", o_voice_midi, exp_midi); end
    @(posedge clk); #1;
    vectors++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL full_ovf_pulse: got %b want 0", o_overflow); end
    // Retrigger of an active note on a full table: no new voice, no overflow.
    send_cmd(on_cmd(7'h43));
    vectors++; if (o_overflow !== 1'b0 || o_active_count !== 3'd4 || o_voice_midi !== exp_midi) begin
      fails++; $display("FAIL full_retrigger: ovf=%b cnt=%0d midi=%h want 0/4/%h", o_overflow, o_active_count, o_voice_midi, exp_midi);
    end
    // Steal-mode ages now v0=1 v1=3 v2=0 v3=2, so voice 1 is oldest.
    send_cmd(on_cmd(7'h4A));
`ifdef VOICE_STEAL_EN
    exp_midi = {7'h47, 7'h43, 7'h4A, 7'h48};
    vectors++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL full_steal2_ovf: got %b want 0", o_overflow); end
`else
    vectors++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL full_drop2_ovf: got %b want 1", o_overflow); end
`endif
    vectors++; if (o_voice_midi !== exp_midi) begin fails++; $display("FAIL full_midi2: got %h want %h", o_voice_midi, exp_midi); end
  endtask

  task automatic test_note_off();
    logic [6:0]       v0_note;
    logic [6:0]       v1_note;
    logic [NV*MW-1:0] exp_midi;
`ifdef VOICE_STEAL_EN
    v0_note = 7'h48; v1_note = 7'h4A;
`else
    v0_note = 7'h3C; v1_note = 7'h40;
`endif
    send_cmd(off_cmd(v1_note));
    exp_midi = {7'h47, 7'h43, 7'h7F, v0_note};
    vectors++; if (o_voice_on !== 4'b1101 || o_active_count !== 3'd3) begin
      fails++; $display("FAIL off_clear: on=%b cnt=%0d want 1101/3", o_voice_on, o_active_count);
    end
    vectors++; if (o_voice_midi !== exp_midi) begin fails++; $display("FAIL off_midi: got %h want %h", o_voice_midi, exp_midi); end
    send_cmd(on_cmd(7'h50));
    exp_midi = {7'h47, 7'h43, 7'h50, v0_note};
    vectors++; if (o_voice_on !== 4'b1111 || o_voice_midi !== exp_midi) begin
      fails++; $display("FAIL off_reuse: on=%b midi=%h want 1111/%h", o_voice_on, o_voice_midi, exp_midi);
    end
    send_cmd(off_cmd(7'h11));
    vectors++; if (o_voice_on !== 4'b1111 || o_voice_midi !== exp_midi || o_active_count !== 3'd4) begin
      fails++; $display("FAIL off_absent: on=%b midi=%h cnt=%0d want 1111/%h/4", o_voice_on, o_voice_midi, o_active_count, exp_midi);
    end
  endtask

  task automatic test_mix();
    logic [SW-1:0] sig;
    int            lat;
    tick_and_capture({4{16'h7FFF}}, sig, lat);
    vectors++; if (lat !== 2) begin fails++; $display("FAIL mix_latency: got %0d want 2", lat); end
    vectors++; if (sig !== 16'h7FFF) begin fails++; $display("FAIL mix_sat_pos: got %h want 7fff", sig); end
    @(posedge clk); #1;
    vectors++; if (o_valid !== 1'b0) begin fails++; $display("FAIL mix_valid_pulse: got %b want 0", o_valid); end
    tick_and_capture({4{16'h8000}}, sig, lat);
    vectors++; if (lat !== 2 || sig !== 16'h8000) begin fails++; $display("FAIL mix_sat_neg: sig=%h lat=%0d want 8000/2", sig, lat); end
    // 100 + 200 - 50 + 7 = 257
    tick_and_capture({16'd7, 16'hFFCE, 16'd200, 16'd100}, sig, lat);
    vectors++; if (lat !== 2 || sig !== 16'h0101) begin fails++; $display("FAIL mix_sum: sig=%h lat=%0d want 0101/2", sig, lat); end
    // Back-to-back ticks give back-to-back results.
    i_voice_sample = {4{16'd1}};
    i_sample_tick  = 1'b1;
    @(posedge clk); #1;
    i_voice_sample = {4{16'd2}};
    @(posedge clk); #1;
    i_sample_tick = 1'b0;
    vectors++; if (o_valid !== 1'b1 || o_signal !== 16'd4) begin fails++; $display("FAIL mix_b2b_first: valid=%b sig=%h want 1/0004", o_valid, o_signal); end
    @(posedge clk); #1;
    vectors++; if (o_valid !== 1'b1 || o_signal !== 16'd8) begin fails++; $display("FAIL mix_b2b_second: valid=%b sig=%h want 1/0008", o_valid, o_signal); end
    @(posedge clk); #1;
    vectors++; if (o_valid !== 1'b0) begin fails++; $display("FAIL mix_b2b_end: got %b want 0", o_valid); end
    // Tick coincident with the note-off of voice 3 still mixes all four voices.
    vectors++; if (o_ready !== 1'b1) begin fails++; $display("FAIL mix_coincide_ready: got %b want 1", o_ready); end
    i_data         = off_cmd(7'h47);
    i_valid        = 1'b1;
    i_voice_sample = {4{16'd1000}};
    i_sample_tick  = 1'b1;
    @(posedge clk); #1;
    i_valid       = 1'b0;
    i_sample_tick = 1'b0;
    vectors++; if (o_active_count !== 3'd3 || o_voice_on !== 4'b0111) begin
      fails++; $display("FAIL mix_coincide_off: cnt=%0d on=%b want 3/0111", o_active_count, o_voice_on);
    end
    @(posedge clk); #1;
    vectors++; if (o_valid !== 1'b1 || o_signal !== 16'h0FA0) begin
      fails++; $display("FAIL mix_pre_update_mask: valid=%b sig=%h want 1/0fa0", o_valid, o_signal);
    end
  endtask

  task automatic test_stop_all();
    logic [SW-1:0] sig;
    int            lat;
    send_cmd(16'h7F00);
    vectors++; if (o_voice_on !== 4'b0 || o_active_count !== 3'd0 || o_voice_midi !== {4{7'h7F}}) begin
      fails++; $display("FAIL stop_all: on=%b cnt=%0d midi=%h want 0/0/%h", o_voice_on, o_active_count, o_voice_midi, {4{7'h7F}});
    end
    tick_and_capture({4{16'h1234}}, sig, lat);
    vectors++; if (lat !== 2 || sig !== 16'h0000) begin fails++; $display("FAIL stop_all_mix: sig=%h lat=%0d want 0000/2", sig, lat); end
    send_cmd(on_cmd(7'h7F));
    vectors++; if (o_active_count !== 3'd0 || o_voice_on !== 4'b0) begin
      fails++; $display("FAIL reserved_note_on: cnt=%0d on=%b want 0/0", o_active_count, o_voice_on);
    end
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    while (!o_ready) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < 8; c++) begin
      i_data  = on_cmd(7'(7'h20 + c));
      i_valid = 1'b1;
      vectors++; if (o_ready !== ((c % 2) == 0)) begin
        fails++; $display("FAIL b2b_ready_c%0d: got %b want %b", c, o_ready, ((c % 2) == 0));
      end
      if (o_ready) accepted++;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    vectors++; if (accepted !== 4) begin fails++; $display("FAIL b2b_accepted: got %0d want 4", accepted); end
    vectors++; if (o_voice_midi !== {7'h26, 7'h24, 7'h22, 7'h20} || o_voice_on !== 4'b1111) begin
      fails++; $display("FAIL b2b_tables: midi=%h on=%b want %h/1111", o_voice_midi, o_voice_on, {7'h26, 7'h24, 7'h22, 7'h20});
    end
  endtask

  task automatic test_reset_midflight();
    logic [SW-1:0] sig;
    int            lat;
    tick_and_capture({4{16'h0010}}, sig, lat);
    vectors++; if (lat !== 2 || sig !== 16'h0040) begin fails++; $display("FAIL midrst_premix: sig=%h lat=%0d want 0040/2", sig, lat); end
    i_voice_sample = {4{16'h0100}};
    i_sample_tick  = 1'b1;
    @(posedge clk); #1;
    i_sample_tick = 1'b0;
    reset_n       = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors++; if (o_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid_c%0d: got %b want 0", c, o_valid); end
      @(posedge clk); #1;
    end
    vectors++; if (o_signal !== 16'h0 || o_overflow !== 1'b0 || o_ready !== 1'b0) begin
      fails++; $display("FAIL midrst_outputs: sig=%h ovf=%b rdy=%b want 0/0/0", o_signal, o_overflow, o_ready);
    end
    vectors++; if (o_voice_on !== 4'b0 || o_active_count !== 3'd0 || o_voice_midi !== {4{7'h7F}}) begin
      fails++; $display("FAIL midrst_tables: on=%b cnt=%0d midi=%h", o_voice_on, o_active_count, o_voice_midi);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      fails++; $display("FAIL midrst_release: rdy=%b valid=%b want 1/0", o_ready, o_valid);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alloc();
    test_full();
    test_note_off();
    test_mix();
    test_stop_all();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
